// File: rtl/adc_emulator.sv
// Emulated parallel ADC: ramp / constant / LFSR / host-stream sample sources feeding
// a fixed-latency pipeline that drives a registered databus launched on the rising edge.
module adc_emulator #(
  parameter int DATA_WIDTH = 10,
  parameter int PIPE_DELAY = 5,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] constValue,
  input  logic [DATA_WIDTH-1:0] streamData,
  input  logic                  streamValid,
  output logic                  streamReady,
  output logic [DATA_WIDTH-1:0] adcDatabus,
  output logic                  adcPrimed,
  output logic                  underflow,
  input  logic                  clearUnderflow
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int FILL_W = $clog2(PIPE_DELAY + 1);

  localparam logic [1:0] MODE_RAMP   = 2'd0;
  localparam logic [1:0] MODE_CONST  = 2'd1;
  localparam logic [1:0] MODE_LFSR   = 2'd2;

  localparam logic [CNT_W-1:0]      FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [FILL_W-1:0]     LAST_FILL  = FILL_W'(PIPE_DELAY - 1);
  localparam logic [DATA_WIDTH-1:0] LFSR_SEED  = DATA_WIDTH'(1);

  // Generator state
  logic [DATA_WIDTH-1:0] ramp_q, ramp_d;
  logic [DATA_WIDTH-1:0] lfsr_q, lfsr_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] sample_d;
  logic                  underflow_set;

  // Stream FIFO
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  fifo_wr, fifo_rd, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;

  // Pipeline and status
  logic [PIPE_DELAY-1:0][DATA_WIDTH-1:0] pipe_q, pipe_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic                  primed_q, primed_d;
  logic                  underflow_q, underflow_d;

  assign streamReady = (count_q != FULL_COUNT);
  assign fifo_empty  = (count_q == '0);
  assign fifo_wr     = streamValid && streamReady;
  assign fifo_head   = fifo_mem[rd_ptr_q];

  // Sample selection; each source only advances while it is the one being emitted.
  always_comb begin
    sample_d      = ramp_q;
    ramp_d        = ramp_q;
    lfsr_d        = lfsr_q;
    hold_d        = hold_q;
    fifo_rd       = 1'b0;
    underflow_set = 1'b0;
    case (mode)
      MODE_RAMP: begin
        sample_d = ramp_q;
        if (enable) ramp_d = ramp_q + DATA_WIDTH'(1);
      end
      MODE_CONST: begin
        sample_d = constValue;
      end
      MODE_LFSR: begin
        sample_d = lfsr_q;
        // Taps q[9]^q[6] for the 10-bit maximal-length x^10+x^7+1 polynomial
        if (enable) lfsr_d = {lfsr_q[DATA_WIDTH-2:0], lfsr_q[DATA_WIDTH-1] ^ lfsr_q[DATA_WIDTH-4]};
      end
      default: begin
        if (fifo_empty) begin
          sample_d      = hold_q;
          underflow_set = enable;
        end else begin
          sample_d = fifo_head;
          fifo_rd  = enable;
          if (enable) hold_d = fifo_head;
        end
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (fifo_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (fifo_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({fifo_wr, fifo_rd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Stage 0 takes the new sample; each later stage takes its predecessor.
  assign pipe_d[0] = sample_d;
  generate
    for (genvar gi = 1; gi < PIPE_DELAY; gi++) begin : g_stage
      assign pipe_d[gi] = pipe_q[gi-1];
    end
  endgenerate

  always_comb begin
    fill_d   = fill_q;
    primed_d = primed_q;
    if (enable && !primed_q) begin
      fill_d = fill_q + FILL_W'(1);
      if (fill_q == LAST_FILL) primed_d = 1'b1;
    end
  end

  always_comb begin
    underflow_d = underflow_q;
    if (underflow_set)       underflow_d = 1'b1;
    else if (clearUnderflow) underflow_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ramp_q      <= '0;
      lfsr_q      <= LFSR_SEED;
      hold_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pipe_q      <= '0;
      fill_q      <= '0;
      primed_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      ramp_q      <= ramp_d;
      lfsr_q      <= lfsr_d;
      hold_q      <= hold_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fill_q      <= fill_d;
      primed_q    <= primed_d;
      underflow_q <= underflow_d;
      if (enable) pipe_q <= pipe_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (fifo_wr) fifo_mem[wr_ptr_q] <= streamData;
  end

  assign adcDatabus = pipe_q[PIPE_DELAY-1];
  assign adcPrimed  = primed_q;
  assign underflow  = underflow_q;

endmodule

// File: doc/adc_emulator.md
Name: adc_emulator

Overview:
- Drives a 10-bit parallel ADC-style databus that stands in for the real RF ADC, for bench and bring-up use.
- Transitions are launched on the rising edge of `clock`, so the ADC-capture logic can sample the bus on the falling edge.
- Sample sources: ramp, constant, LFSR, or a host-fed sample stream through an internal FIFO.
- Sits between the test/control logic and the ADC capture input, replacing the physical ADC pins.

Parameters:
- DATA_WIDTH, 10, sample width in bits.
- PIPE_DELAY, 5, emulated ADC pipeline latency in enabled clocks; legal range 1..16.
- FIFO_DEPTH, 16, stream FIFO entries; power of two, minimum 2.

Ports:
- clock  input  1  sample clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = generate and shift one sample per clock; 0 = freeze all generator and pipeline state.
- mode  input  2  source select: 0 ramp, 1 constant, 2 LFSR, 3 stream.
- constValue  input  DATA_WIDTH  sample value used in mode 1.
- streamData  input  DATA_WIDTH  host sample written into the FIFO.
- streamValid  input  1  host sample present.
- streamReady  output  1  FIFO can accept a write (not full).
- adcDatabus  output  DATA_WIDTH  emulated ADC output bus; registered.
- adcPrimed  output  1  pipeline filled; adcDatabus now carries generated samples.
- underflow  output  1  sticky flag: a stream-mode read found the FIFO empty.
- clearUnderflow  input  1  clears underflow.

Behaviour:
- Reset (synchronous, `reset`=1 at a rising edge):
  - Outputs: adcDatabus=0, adcPrimed=0, underflow=0, streamReady=1.
  - State: FIFO flushed, ramp counter=0, LFSR=10'h001, pipeline stages=0, stream hold register=0.
  - Reset mid-operation discards all in-flight samples; the first post-reset enabled sample is again ramp 0 / LFSR 001.
- Generation: each enabled clock, one sample is produced from the source selected by `mode` in that cycle.
  - Ramp: emits counter, then counter+1 modulo 2^DATA_WIDTH (1023→0).
  - Constant: emits constValue as sampled that cycle.
  - LFSR: emits current state, then advances. Fibonacci x^10+x^7+1, fb=q[9]^q[6], next={q[8:0],fb}. Period 1023; never 0.
  - Stream, FIFO non-empty: pops the head and emits it; the value is also stored in the hold register.
  - Stream, FIFO empty: emits the hold register and sets underflow.
- Ramp counter and LFSR advance only in cycles where their mode is selected and enable=1. A mode change takes effect on the next generated sample, with no flush or reseed.
- Pipeline:
  - The generated sample enters a PIPE_DELAY-stage shift register; adcDatabus is the last stage.
  - A sample generated in enabled cycle N appears on adcDatabus after exactly PIPE_DELAY enabled clocks.
  - enable=0 freezes the pipeline and adcDatabus holds its value.
- adcPrimed: rises on the same edge that the first generated sample reaches adcDatabus (PIPE_DELAY enabled clocks after reset). It stays 1 until reset.
- FIFO:
  - streamReady = (count != FIFO_DEPTH), derived from registered count.
  - Write occurs when streamValid && streamReady, independent of enable and mode.
  - Read occurs only in stream mode with enable=1 and count>0.
  - Simultaneous read and write: count unchanged, data order preserved.
  - Full: streamReady=0 even if a read happens that cycle; no write is lost or overwritten.
  - Empty with simultaneous write: no bypass; the read underflows and the written word is emitted next cycle.
- underflow: set by an empty read, cleared by clearUnderflow. Set wins over clear in the same cycle.
- Widths: all arithmetic is modulo 2^DATA_WIDTH, with no saturation.

Test Plan:
- Ramp, PIPE_DELAY=5: release reset with enable=1, mode=0 → adcDatabus=0 and adcPrimed=0 for 5 clocks; adcPrimed rises with the first sample; bus shows 0,1,2,…; after 1024 samples it wraps 1023→0.
- LFSR: mode=2 after reset → bus emits 001,002,004,008,010,020,040,081,102,204,009 in order; over 1023 samples every nonzero value appears once; the sequence repeats at sample 1024.
- Enable gating: ramp running, deassert enable for 7 clocks mid-stream → bus frozen at its last value; after re-enable the sequence continues with no skipped or repeated value.
- Stream/FIFO, FIFO_DEPTH=16: write 16 words 0x3A0..0x3AF while enable=0 → streamReady=0 after the 16th. Extra write with valid held → not accepted. Set mode=3, enable=1 → bus shows 0x3A0..0x3AF after PIPE_DELAY clocks, then 0x3AF repeats, underflow=1.
- Underflow clear race: underflow set; assert clearUnderflow in a cycle that also underflows → flag stays 1. Next cycle, clear with the FIFO non-empty → flag becomes 0.
- Reset mid-stream: apply a 1-cycle reset during LFSR output with the FIFO half full → next edge shows bus=0, adcPrimed=0, streamReady=1. After PIPE_DELAY enabled clocks the bus restarts at 001 (mode 2).
